// File: rtl/self_ex_slink_pkg.sv
// Shared definitions for the SLINK per-channel receive monitor: link states,
// default thresholds and the saturating error-counter helper.
package self_ex_slink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_OK    = 2'd2,
        ST_FAULT = 2'd3
    } link_state_t;

    localparam int DEF_TIMEOUT_CYC  = 1250;   // 100 us at 12.5 MHz
    localparam int DEF_ERR_THRESH   = 3;
    localparam int DEF_RECOV_THRESH = 4;
    localparam int DEF_WDOG_W       = 16;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
        return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/self_ex_slink_wdog.sv
// Frame-gap watchdog: counts idle cycles while running and flags expiry when
// TIMEOUT_CYC cycles pass without a kick.
module self_ex_slink_wdog #(
    parameter int TIMEOUT_CYC = 1250,
    parameter int WDOG_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam logic [WDOG_W-1:0] CNT_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    logic [WDOG_W-1:0] cnt;

    // A kick in the terminal cycle wins over expiry.
    assign expire = run & ~kick & (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || kick || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/self_ex_slink_mon.sv
// Per-channel SLINK receive-link monitor. frame_vld is a one-cycle strobe with
// no back-pressure; frame_crc_err is meaningful only in the cycle frame_vld is high.
module self_ex_slink_mon
    import self_ex_slink_pkg::*;
#(
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int ERR_THRESH   = DEF_ERR_THRESH,
    parameter int RECOV_THRESH = DEF_RECOV_THRESH,
    parameter int WDOG_W       = DEF_WDOG_W
) (
    input  logic       clk_12_5m,
    input  logic       rst_12_5m,
    input  logic       chn_enable,
    input  logic       frame_vld,
    input  logic       frame_crc_err,
    input  logic       link_los,
    output logic       chn_slink_err,
    output logic [1:0] link_state,
    output logic [7:0] err_cnt,
    output logic       timeout_flag
);

    localparam int CNT_W = $clog2(((ERR_THRESH > RECOV_THRESH) ? ERR_THRESH : RECOV_THRESH) + 1);
    localparam logic [CNT_W-1:0] BAD_LAST  = CNT_W'(ERR_THRESH - 1);
    localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(RECOV_THRESH - 1);

    link_state_t      state;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;
    logic             good;
    logic             bad;
    logic             wdog_run;
    logic             wdog_kick;
    logic             expire;

    assign good     = frame_vld & ~frame_crc_err;
    assign bad      = frame_vld & frame_crc_err;
    assign wdog_run = chn_enable & (state != ST_IDLE);
    // Every state change coincides with a frame, an expiry or LOS entering FAULT;
    // only the LOS case needs an explicit reload.
    assign wdog_kick = frame_vld | (link_los & (state != ST_FAULT));

    assign link_state = state;

    self_ex_slink_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .WDOG_W      (WDOG_W)
    ) u_wdog (
        .clk    (clk_12_5m),
        .rst    (rst_12_5m),
        .run    (wdog_run),
        .kick   (wdog_kick),
        .expire (expire)
    );

    always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
        if (rst_12_5m) begin
            state         <= ST_IDLE;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            err_cnt       <= '0;
            chn_slink_err <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            timeout_flag <= expire;
            if (!chn_enable) begin
                state         <= ST_IDLE;
                good_cnt      <= '0;
                bad_cnt       <= '0;
                err_cnt       <= '0;
                chn_slink_err <= 1'b0;
            end else if (state == ST_IDLE) begin
                state         <= ST_ACQ;
                good_cnt      <= '0;
                bad_cnt       <= '0;
                chn_slink_err <= 1'b1;
            end else begin
                if (bad || expire) begin
                    err_cnt <= err_cnt_inc(err_cnt);
                end
                if (link_los) begin
                    state         <= ST_FAULT;
                    good_cnt      <= '0;
                    chn_slink_err <= 1'b1;
                end else if (state == ST_OK) begin
                    if (bad) begin
                        if (bad_cnt == BAD_LAST) begin
                            state         <= ST_FAULT;
                            bad_cnt       <= '0;
                            chn_slink_err <= 1'b1;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end else if (good) begin
                        bad_cnt <= '0;
                    end else if (expire) begin
                        state         <= ST_FAULT;
                        chn_slink_err <= 1'b1;
                    end
                end else begin
                    // ACQ and FAULT share the recovery path.
                    if (good) begin
                        if (good_cnt == GOOD_LAST) begin
                            state         <= ST_OK;
                            good_cnt      <= '0;
                            bad_cnt       <= '0;
                            chn_slink_err <= 1'b0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end else if (bad || expire) begin
                        good_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_self_ex_slink_mon.sv
// Directed bench for self_ex_slink_mon: the driver queues hand-computed
// expectations per cycle and a negedge monitor pops and compares them.
module tb_self_ex_slink_mon;
    import self_ex_slink_pkg::*;

    logic       clk_12_5m = 1'b0;
    logic       rst_12_5m;
    logic       chn_enable;
    logic       frame_vld;
    logic       frame_crc_err;
    logic       link_los;
    logic       chn_slink_err;
    logic [1:0] link_state;
    logic [7:0] err_cnt;
    logic       timeout_flag;

    self_ex_slink_mon dut (
        .clk_12_5m     (clk_12_5m),
        .rst_12_5m     (rst_12_5m),
        .chn_enable    (chn_enable),
        .frame_vld     (frame_vld),
        .frame_crc_err (frame_crc_err),
        .link_los      (link_los),
        .chn_slink_err (chn_slink_err),
        .link_state    (link_state),
        .err_cnt       (err_cnt),
        .timeout_flag  (timeout_flag)
    );

    // clock / reset
    always #40 clk_12_5m = ~clk_12_5m;

    int cyc = 0;
    always @(posedge clk_12_5m) cyc++;

    // scoreboard: {state, slink_err, timeout_flag, err_cnt}
    logic [11:0] exp_q[$];
    int          exp_cyc_q[$];
    string       exp_name_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          e      = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got state=%0d slink_err=%0b timeout=%0b err_cnt=%0d, want state=%0d slink_err=%0b timeout=%0b err_cnt=%0d",
                     name, $time, act[11:10], act[9], act[8], act[7:0],
                     exp[11:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    always @(negedge clk_12_5m) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            void'(exp_cyc_q.pop_front());
            check(exp_name_q.pop_front(), {link_state, chn_slink_err, timeout_flag, err_cnt},
                  exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_12_5m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // expectation for the outputs right after the next active edge
    task automatic push_exp(input string name, input logic [1:0] st, input logic se,
                            input logic to, input int cnt);
        exp_q.push_back({st, se, to, 8'(cnt)});
        exp_cyc_q.push_back(cyc + 1);
        exp_name_q.push_back(name);
    endtask

    task automatic send_frame(input logic crc);
        frame_vld     = 1'b1;
        frame_crc_err = crc;
        tick();
        frame_vld     = 1'b0;
        frame_crc_err = 1'b0;
    endtask

    task automatic good_frame(input string name, input logic [1:0] st, input logic se);
        push_exp(name, st, se, 1'b0, e);
        send_frame(1'b0);
    endtask

    task automatic bad_frame(input string name, input logic [1:0] st, input logic se);
        e = (e >= 255) ? 255 : e + 1;
        push_exp(name, st, se, 1'b0, e);
        send_frame(1'b1);
    endtask

    // idle until the watchdog has counted 1249, then the expiring edge
    task automatic timeout_in(input string name, input logic [1:0] st_after);
        idle(1249);
        e = (e >= 255) ? 255 : e + 1;
        push_exp(name, st_after, 1'b1, 1'b1, e);
        tick();
    endtask

    initial begin
        rst_12_5m     = 1'b1;
        chn_enable    = 1'b0;
        frame_vld     = 1'b0;
        frame_crc_err = 1'b0;
        link_los      = 1'b0;
        tick();
        push_exp("reset", ST_IDLE, 1'b0, 1'b0, 0);
        tick();
        rst_12_5m = 1'b0;
        push_exp("idle_disabled", ST_IDLE, 1'b0, 1'b0, 0);
        tick();

        // enable, acquire with 4 good frames
        chn_enable = 1'b1;
        push_exp("enable_acq", ST_ACQ, 1'b1, 1'b0, 0);
        tick();
        for (int i = 0; i < 3; i++) good_frame("acq_good", ST_ACQ, 1'b1);
        good_frame("acq_to_ok", ST_OK, 1'b0);

        // stray CRC error without frame_vld is ignored
        frame_crc_err = 1'b1;
        push_exp("crc_no_vld", ST_OK, 1'b0, 1'b0, e);
        tick();
        frame_crc_err = 1'b0;

        // bad frames in OK: non-consecutive do not fault, 3 consecutive do
        bad_frame("ok_bad1", ST_OK, 1'b0);
        bad_frame("ok_bad2", ST_OK, 1'b0);
        good_frame("ok_good_clr", ST_OK, 1'b0);
        bad_frame("ok_bad3", ST_OK, 1'b0);
        bad_frame("ok_bad4", ST_OK, 1'b0);
        bad_frame("ok_to_fault", ST_FAULT, 1'b1);

        // recovery in FAULT restarts on a bad frame
        for (int i = 0; i < 3; i++) good_frame("fault_good", ST_FAULT, 1'b1);
        bad_frame("fault_bad", ST_FAULT, 1'b1);
        for (int i = 0; i < 3; i++) good_frame("fault_good2", ST_FAULT, 1'b1);
        good_frame("fault_to_ok", ST_OK, 1'b0);

        // watchdog: frame coincident with the terminal count wins, then a real expiry
        idle(1248);
        push_exp("wdog_no_early", ST_OK, 1'b0, 1'b0, e);
        tick();
        good_frame("wdog_frame_wins", ST_OK, 1'b0);
        timeout_in("wdog_expire", ST_FAULT);
        push_exp("wdog_pulse_end", ST_FAULT, 1'b1, 1'b0, e);
        tick();
        for (int i = 0; i < 3; i++) good_frame("rec_good", ST_FAULT, 1'b1);
        good_frame("rec_ok", ST_OK, 1'b0);

        // LOS with a simultaneous good frame goes to FAULT
        link_los = 1'b1;
        good_frame("los_fault", ST_FAULT, 1'b1);
        link_los = 1'b0;

        // err_cnt saturation through timeouts and bad frames
        timeout_in("fault_timeout1", ST_FAULT);
        timeout_in("fault_timeout2", ST_FAULT);
        for (int i = 0; i < 250; i++) bad_frame("sat_bad", ST_FAULT, 1'b1);
        timeout_in("sat_timeout", ST_FAULT);

        // disable mid-FAULT
        chn_enable = 1'b0;
        e = 0;
        push_exp("disable_idle", ST_IDLE, 1'b0, 1'b0, 0);
        tick();
        chn_enable = 1'b1;
        push_exp("reenable_acq", ST_ACQ, 1'b1, 1'b0, 0);
        tick();
        for (int i = 0; i < 3; i++) good_frame("re_acq_good", ST_ACQ, 1'b1);
        good_frame("re_ok", ST_OK, 1'b0);
        bad_frame("re_ok_bad", ST_OK, 1'b0);

        // asynchronous reset between edges
        @(posedge clk_12_5m);
        #20;
        rst_12_5m = 1'b1;
        #1;
        check("async_reset", {link_state, chn_slink_err, timeout_flag, err_cnt}, 12'h000);
        tick();
        rst_12_5m = 1'b0;
        e = 0;
        push_exp("post_reset_acq", ST_ACQ, 1'b1, 1'b0, 0);
        tick();

        idle(2);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/self_ex_slink_mon.md
Name: self_ex_slink_mon

Overview:
Per-channel SLINK receive-link monitor; produces the single-channel `chn_slink_err` bit consumed by the SLINK diagnostic stage.
- Two instances per module, one per redundant channel, concatenated into `chn_slink_err[1:0]`.
- Qualifies received-frame events, CRC errors, loss-of-signal and frame-gap timeout through a 4-state link FSM.
- Fault is raised after repeated errors; recovery requires consecutive good frames.

Parameters:
- TIMEOUT_CYC, 1250: max cycles between frames before timeout (100 us at 12.5 MHz).
- ERR_THRESH, 3: consecutive bad frames that cause FAULT.
- RECOV_THRESH, 4: consecutive good frames needed to reach OK.
- WDOG_W, 16: watchdog counter width; must satisfy 2^WDOG_W > TIMEOUT_CYC.

Ports:
- clk_12_5m  in  1  sole clock.
- rst_12_5m  in  1  asynchronous reset, active-high.
- chn_enable  in  1  channel enabled by configuration, already synchronous.
- frame_vld  in  1  one-cycle pulse at the end of each received frame.
- frame_crc_err  in  1  CRC failure for the current frame; valid only with frame_vld.
- link_los  in  1  loss-of-signal level, already synchronous.
- chn_slink_err  out  1  channel error flag.
- link_state  out  2  current FSM state.
- err_cnt  out  8  saturating count of bad frames plus timeouts since enable.
- timeout_flag  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset: state IDLE; chn_slink_err=0, link_state=0, err_cnt=0, timeout_flag=0; all internal counters 0.
- Event definitions:
  - good = frame_vld & ~frame_crc_err.
  - bad = frame_vld & frame_crc_err.
  - frame_crc_err without frame_vld is ignored.
- States and encoding: IDLE=0, ACQ=1, OK=2, FAULT=3.
- Transitions, evaluated in priority order each edge:
  1. chn_enable=0 -> IDLE from any state. Clears good_cnt, bad_cnt, watchdog, err_cnt.
  2. IDLE & chn_enable=1 -> ACQ. Counters cleared.
  3. link_los=1 in ACQ/OK/FAULT -> FAULT; good_cnt cleared. A simultaneous good frame is ignored.
  4. OK:
     - bad increments bad_cnt; reaching ERR_THRESH -> FAULT.
     - good clears bad_cnt.
     - watchdog expiry -> FAULT.
  5. ACQ/FAULT:
     - good increments good_cnt; reaching RECOV_THRESH -> OK, with good_cnt and bad_cnt cleared.
     - bad clears good_cnt.
     - watchdog expiry clears good_cnt; state is held.
- chn_slink_err:
  - Registered; updated on the same edge as the state register.
  - 1 in ACQ and FAULT, 0 in IDLE and OK.
  - Latency from the triggering input to the output change is 1 clock.
- Watchdog:
  - Runs in ACQ/OK/FAULT; reloads to 0 on any frame_vld and on every state change.
  - Expiry fires when the count equals TIMEOUT_CYC-1 and frame_vld=0. On expiry, timeout_flag pulses for 1 cycle and the count restarts at 0.
  - A frame_vld in the expiry cycle wins: no timeout.
- err_cnt:
  - +1 per bad frame, +1 per expiry; a simultaneous bad frame and expiry cannot occur.
  - Saturates at 255; cleared only on entry to IDLE and on reset.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). After release, the block restarts from IDLE.

Decomposition:
- Package self_ex_slink_pkg:
  - State encodings ST_IDLE, ST_ACQ, ST_OK, ST_FAULT.
  - Default threshold constants.
  - ERR_CNT_MAX=255.
- Sub-module self_ex_slink_wdog, ports: clk, rst, run, kick, expire. It holds the TIMEOUT_CYC counter; the FSM and counters stay in the top module.

Test Plan:
All scenarios use the default parameters.
1. Reset, then chn_enable=1, then 4 good frames -> chn_slink_err=1 from the edge after enable until the edge after the 4th frame, then 0; link_state=2.
2. In OK: 2 bad, 1 good, 2 bad -> stays OK, err_cnt=4. A further bad (3rd consecutive) -> FAULT, chn_slink_err=1, err_cnt=5.
3. In OK with no frames -> timeout_flag pulses and state becomes FAULT at cycle 1250. A frame at cycle 1249 prevents the timeout. A good frame coincident with the expiry count -> no timeout.
4. In FAULT: 3 good, 1 bad, 4 good -> OK only on the edge after the final good frame.
5. link_los pulse in OK coincident with a good frame -> FAULT next edge. Then 300 timeouts -> err_cnt saturates at 255.
6. chn_enable=0 mid-FAULT -> IDLE, chn_slink_err=0, err_cnt=0. rst_12_5m asserted mid-OK -> all outputs 0 without waiting for a clock edge.
